uart_tx_fifo: RTL and testbench

Byte FIFO and launch sequencer directly upstream of the UART transmitter. It accepts bursts of bytes from a producer (CPU bus bridge or debug logic) and buffers them. It drains them one at a time into the UART wrapper's TX_dataIn/TX_en interface, pacing on TX_busy/TX_done, so producers never have to poll the transmitter.

---
 rtl/uart_tx_fifo.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO plus launch sequencer sitting in front of the UART transmitter.
//   Producers push bytes at up to one per cycle; the sequencer hands them to
//   the UART one at a time and paces on tx_busy / tx_done.
//
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous reset, active low
//   wr_data   byte to enqueue
//   wr_en     enqueue strobe
//   flush     synchronous clear of FIFO contents (wins over wr_en)
//   full      FIFO holds DEPTH bytes
//   empty     FIFO holds 0 bytes
//   drained   FIFO empty and sequencer idle
//   tx_data   byte presented to the UART, held until the next launch
//   tx_en     single-cycle launch pulse to the UART
//   tx_busy   UART frame in progress
//   tx_done   UART frame finished
//
// Build option
//   UART_TX_FIFO_STATUS_EN adds outputs level (occupancy 0..DEPTH) and a
//   sticky overflow flag (set on a dropped write, cleared by flush/reset).
//
// FSM states
//   state        | meaning
//   ST_IDLE      | nothing in flight; launch head byte when FIFO non-empty and UART free
//   ST_WAIT_BUSY | launched; waiting up to BUSY_WAIT cycles for the UART to go busy
//   ST_WAIT_DONE | UART transmitting; waiting for tx_done or tx_busy to drop

module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = $clog2(DEPTH),
   parameter int BUSY_WAIT  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   input  logic                  flush,
   output logic                  full,
   output logic                  empty,
   output logic                  drained,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  tx_en,
   input  logic                  tx_busy,
   input  logic                  tx_done
`ifdef UART_TX_FIFO_STATUS_EN
   ,
   output logic [ADDR_W:0]       level,
   output logic                  overflow
`endif
);

   localparam int CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_BUSY = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  tx_en_q, tx_en_d;
   logic                  push;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                    (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   assign drained = empty && (state_q == ST_IDLE);
   assign tx_data = tx_data_q;
   assign tx_en   = tx_en_q;

   assign push     = wr_en && !full && !flush;
   assign wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push};

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tx_en_d   = 1'b0;
      tx_data_d = tx_data_q;
      rd_ptr_d  = rd_ptr_q;

      case (state_q)
         ST_IDLE: begin
            if (!empty && !tx_busy) begin
               tx_en_d   = 1'b1;
               tx_data_d = mem_q[rd_ptr_q[ADDR_W-1:0]];
               rd_ptr_d  = rd_ptr_q + 1'b1;
               cnt_d     = CNT_W'(BUSY_WAIT - 1);
               state_d   = ST_WAIT_BUSY;
            end
         end
         ST_WAIT_BUSY: begin
            // Timeout counts the launch cycle itself; a missed byte is not retried.
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (tx_done) begin
               state_d = ST_IDLE;
            end else if (cnt_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (tx_done || !tx_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Flush empties the queue but leaves an in-flight byte alone.
      if (flush) begin
         rd_ptr_d = wr_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         tx_data_q <= '0;
         tx_en_q   <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
      end
   end

`ifdef UART_TX_FIFO_STATUS_EN
   logic overflow_q, overflow_d;

   assign level    = wr_ptr_q - rd_ptr_q;
   assign overflow = overflow_q;

   always_comb begin
      overflow_d = overflow_q;
      if (flush) begin
         overflow_d = 1'b0;
      end else if (wr_en && full) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

   localparam int DW        = 8;
   localparam int DEPTH     = 16;
   localparam int AW        = 4;
   localparam int BUSY_WAIT = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic          flush = 1'b0;
   logic          tx_busy = 1'b0;
   logic          tx_done = 1'b0;
   logic          full, empty, drained, tx_en;
   logic [DW-1:0] tx_data;
`ifdef UART_TX_FIFO_STATUS_EN
   logic [AW:0]   level;
   logic          overflow;
`endif

   uart_tx_fifo #(
      .DATA_WIDTH(DW),
      .DEPTH(DEPTH),
      .BUSY_WAIT(BUSY_WAIT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wr_data(wr_data),
      .wr_en(wr_en),
      .flush(flush),
      .full(full),
      .empty(empty),
      .drained(drained),
      .tx_data(tx_data),
      .tx_en(tx_en),
      .tx_busy(tx_busy),
      .tx_done(tx_done)
`ifdef UART_TX_FIFO_STATUS_EN
      ,
      .level(level),
      .overflow(overflow)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: byte queue, sticky overflow, last byte handed to the UART.
   logic [DW-1:0] mq[$];
   bit            m_ovf;
   logic [DW-1:0] last_tx;
   int            launches;
   int            n_total;
   int            n_pass;

   // UART responder model: 0 = normal frames, 1 = stalled busy, 2 = dead line.
   int umode;
   int u_phase;
   int u_wait;
   int u_len;

   task automatic reset_models();
      mq.delete();
      m_ovf   = 1'b0;
      last_tx = '0;
      u_phase = 0;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      wr_en   = 1'b0;
      flush   = 1'b0;
   endtask

   // One clock cycle: apply current inputs, advance the model, check, update UART model.
   task automatic step();
      bit            was_full;
      bit            wr_pre;
      bit            fl_pre;
      bit            busy_pre;
      logic [DW-1:0] wd_pre;
      was_full = (mq.size() == DEPTH);
      wr_pre   = wr_en;
      fl_pre   = flush;
      busy_pre = tx_busy;
      wd_pre   = wr_data;
      @(posedge clk);
      #1;
      if (tx_en === 1'b1) begin
         launches++;
         n_total++;
         if (busy_pre !== 1'b0) $display("FAIL tx_en_while_busy: tx_busy=%0b required 0", busy_pre);
         else n_pass++;
         n_total++;
         if (mq.size() == 0) begin
            $display("FAIL tx_en_underflow: launch with model queue empty, tx_data=%0h", tx_data);
         end else begin
            if (tx_data !== mq[0]) $display("FAIL tx_data_order: got %0h required %0h", tx_data, mq[0]);
            else n_pass++;
            last_tx = mq.pop_front();
         end
      end else begin
         n_total++;
         if (tx_data !== last_tx) $display("FAIL tx_data_hold: got %0h required %0h", tx_data, last_tx);
         else n_pass++;
      end
      if (fl_pre) begin
         mq.delete();
         m_ovf = 1'b0;
      end else if (wr_pre) begin
         if (was_full) m_ovf = 1'b1;
         else mq.push_back(wd_pre);
      end
      n_total++;
      if (empty !== (mq.size() == 0)) $display("FAIL empty: got %0b required %0b", empty, mq.size() == 0);
      else n_pass++;
      n_total++;
      if (full !== (mq.size() == DEPTH)) $display("FAIL full: got %0b required %0b", full, mq.size() == DEPTH);
      else n_pass++;
      n_total++;
      if ((drained === 1'b1) && (mq.size() != 0)) $display("FAIL drained_nonempty: drained=1 with %0d queued", mq.size());
      else n_pass++;
`ifdef UART_TX_FIFO_STATUS_EN
      n_total++;
      if (level !== (AW+1)'(mq.size())) $display("FAIL level: got %0d required %0d", level, mq.size());
      else n_pass++;
      n_total++;
      if (overflow !== m_ovf) $display("FAIL overflow: got %0b required %0b", overflow, m_ovf);
      else n_pass++;
`endif
      case (umode)
         1: begin tx_busy = 1'b1; tx_done = 1'b0; end
         2: begin tx_busy = 1'b0; tx_done = 1'b0; end
         default: begin
            tx_done = 1'b0;
            if (u_phase == 1) begin
               if (u_wait == 0) begin tx_busy = 1'b1; u_phase = 2; end
               else u_wait--;
            end else if (u_phase == 2) begin
               if (u_len == 0) begin tx_busy = 1'b0; tx_done = 1'b1; u_phase = 0; end
               else u_len--;
            end
            if (tx_en === 1'b1) begin
               u_phase = 1;
               u_wait  = $urandom_range(0, 1);
               u_len   = $urandom_range(2, 8);
            end
         end
      endcase
   endtask

   task automatic wait_drained(input int budget);
      int k;
      k = 0;
      while (drained !== 1'b1 && k < budget) begin
         step();
         k++;
      end
      n_total++;
      if (drained !== 1'b1) $display("FAIL drain_timeout: drained=%0b after %0d cycles, required 1", drained, budget);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #1;
      n_total++;
      if ({empty, full, drained, tx_en, tx_data} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00})
         $display("FAIL reset_async: e/f/d/en/data=%0b%0b%0b%0b/%0h required 1010/00", empty, full, drained, tx_en, tx_data);
      else n_pass++;
      repeat (10) @(posedge clk);
      #1;
      n_total++;
      if ({empty, full, drained, tx_en, tx_data} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00})
         $display("FAIL reset_hold: e/f/d/en/data=%0b%0b%0b%0b/%0h required 1010/00", empty, full, drained, tx_en, tx_data);
      else n_pass++;
`ifdef UART_TX_FIFO_STATUS_EN
      n_total++;
      if ({level, overflow} !== '0) $display("FAIL reset_status: level=%0d overflow=%0b required 0/0", level, overflow);
      else n_pass++;
`endif
      @(negedge clk);
      rst = 1'b1;
      reset_models();
      repeat (3) step();
      n_total++;
      if (drained !== 1'b1) $display("FAIL idle_drained: got %0b required 1", drained);
      else n_pass++;
   endtask

   task automatic test_single();
      int l0;
      umode = 0;
      l0 = launches;
      wr_en = 1'b1;
      wr_data = 8'hA5;
      step();
      wr_en = 1'b0;
      n_total++;
      if (tx_en !== 1'b0) $display("FAIL single_early: tx_en=%0b required 0", tx_en);
      else n_pass++;
      step();
      n_total++;
      if (tx_en !== 1'b1 || tx_data !== 8'hA5) $display("FAIL single_launch: tx_en=%0b data=%0h required 1/a5", tx_en, tx_data);
      else n_pass++;
      wait_drained(100);
      n_total++;
      if (launches - l0 != 1 || tx_data !== 8'hA5) $display("FAIL single_count: launches=%0d data=%0h required 1/a5", launches - l0, tx_data);
      else n_pass++;
   endtask

   task automatic test_busy_timeout();
      umode = 2;
      tx_busy = 1'b0;
      tx_done = 1'b0;
      wr_en = 1'b1;
      wr_data = 8'h3C;
      step();
      wr_en = 1'b0;
      step();
      n_total++;
      if (tx_en !== 1'b1) $display("FAIL timeout_launch: tx_en=%0b required 1", tx_en);
      else n_pass++;
      for (int i = 0; i < BUSY_WAIT - 1; i++) begin
         step();
         n_total++;
         if (drained !== 1'b0) $display("FAIL timeout_early: drained=%0b at cycle %0d required 0", drained, i + 1);
         else n_pass++;
      end
      step();
      n_total++;
      if (drained !== 1'b1) $display("FAIL timeout_return: drained=%0b required 1", drained);
      else n_pass++;
      umode = 0;
   endtask

   task automatic test_back_to_back();
      int l0;
      umode = 0;
      l0 = launches;
      for (int i = 1; i <= 16; i++) begin
         wr_en = 1'b1;
         wr_data = 8'(i);
         step();
      end
      wr_en = 1'b0;
      wait_drained(600);
      n_total++;
      if (launches - l0 != 16) $display("FAIL burst_count: launches=%0d required 16", launches - l0);
      else n_pass++;
      n_total++;
      if (tx_data !== 8'h10) $display("FAIL burst_last: tx_data=%0h required 10", tx_data);
      else n_pass++;
   endtask

   task automatic test_overflow();
      umode = 1;
      tx_busy = 1'b1;
      step();
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1;
         wr_data = 8'($urandom);
         step();
         if (i == 15) begin
            n_total++;
            if (full !== 1'b1) $display("FAIL ovf_full: full=%0b required 1", full);
            else n_pass++;
         end
      end
      wr_en = 1'b0;
`ifdef UART_TX_FIFO_STATUS_EN
      n_total++;
      if (level !== 5'd16 || overflow !== 1'b1) $display("FAIL ovf_status: level=%0d overflow=%0b required 16/1", level, overflow);
      else n_pass++;
`endif
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_total++;
      if (empty !== 1'b1) $display("FAIL ovf_flush: empty=%0b required 1", empty);
      else n_pass++;
      umode = 0;
      tx_busy = 1'b0;
      u_phase = 0;
      step();
   endtask

   task automatic test_flush_midframe();
      int l0;
      int k;
      umode = 0;
      l0 = launches;
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1;
         wr_data = 8'($urandom);
         step();
      end
      wr_en = 1'b0;
      k = 0;
      while (tx_busy !== 1'b1 && k < 20) begin step(); k++; end
      n_total++;
      if (tx_busy !== 1'b1 || launches - l0 != 1) $display("FAIL flush_setup: busy=%0b launches=%0d required 1/1", tx_busy, launches - l0);
      else n_pass++;
      flush = 1'b1;
      step();
      flush = 1'b0;
      wait_drained(100);
      n_total++;
      if (launches - l0 != 1) $display("FAIL flush_extra_launch: launches=%0d required 1", launches - l0);
      else n_pass++;
   endtask

   task automatic test_random();
      umode = 0;
      for (int i = 0; i < 400; i++) begin
         wr_en   = ($urandom_range(0, 2) != 0);
         wr_data = 8'($urandom);
         flush   = ($urandom_range(0, 39) == 0);
         step();
      end
      wr_en = 1'b0;
      flush = 1'b0;
      wait_drained(1000);
      n_total++;
      if (mq.size() != 0) $display("FAIL random_leftover: model holds %0d bytes required 0", mq.size());
      else n_pass++;
   endtask

   task automatic test_reset_midframe();
      int k;
      umode = 0;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1;
         wr_data = 8'($urandom_range(1, 255));
         step();
      end
      wr_en = 1'b0;
      k = 0;
      while (tx_busy !== 1'b1 && k < 20) begin step(); k++; end
      #2;
      rst = 1'b0;
      #1;
      n_total++;
      if ({empty, full, drained, tx_en, tx_data} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00})
         $display("FAIL reset_midframe: e/f/d/en/data=%0b%0b%0b%0b/%0h required 1010/00", empty, full, drained, tx_en, tx_data);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      reset_models();
      step();
      n_total++;
      if (drained !== 1'b1 || tx_en !== 1'b0) $display("FAIL reset_release: drained=%0b tx_en=%0b required 1/0", drained, tx_en);
      else n_pass++;
   endtask

   initial begin
      n_total  = 0;
      n_pass   = 0;
      launches = 0;
      umode    = 0;
      u_phase  = 0;
      u_wait   = 0;
      u_len    = 0;
      m_ovf    = 1'b0;
      last_tx  = '0;
      test_reset();
      test_single();
      test_busy_timeout();
      test_back_to_back();
      test_overflow();
      test_flush_midframe();
      test_random();
      test_reset_midframe();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
